// File: rtl/maxpool_stream_if.sv
// Stream bundle for maxpool_stream: one pixel input channel, one pooled output channel
// and the end-of-frame pulse. The master side is the environment; the slave side is the pooling block.
interface maxpool_stream_if #(
    parameter int DATAWIDTH = 16
) ();
    // Valid/ready: a beat happens on a rising clock edge where VALID and READY are both 1.
    // A source keeps DATA/VALID steady while VALID=1 and READY=0; READY may depend on the peer.
    logic [DATAWIDTH-1:0] IN_DATA;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [DATAWIDTH-1:0] OUT_DATA;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic                 FRAME_DONE;

    modport master (
        output IN_DATA, IN_VALID, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_VALID, FRAME_DONE
    );

    modport slave (
        input  IN_DATA, IN_VALID, OUT_READY,
        output IN_READY, OUT_DATA, OUT_VALID, FRAME_DONE
    );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 2x2 max-pool over a row-major frame: horizontal pair max on odd columns,
// pairs of even rows parked in a half-width line buffer, window max emitted on odd rows.
module maxpool_stream #(
    parameter int DATAWIDTH = 16,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int SIGNED    = 0
) (
    input logic            CLK,
    input logic            rst,
    maxpool_stream_if.slave bus
);
    localparam int LB_N  = IMG_W / 2;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    typedef logic [DATAWIDTH-1:0] pix_t;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    pix_t             hold_q, hold_d;
    pix_t             out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;

    pix_t             lb_q [LB_N];
    logic             lb_we;
    logic [LB_AW-1:0] lb_idx;

    logic             in_ready;
    logic             in_beat;
    logic             out_beat;
    logic             col_last;
    logic             row_last;
    pix_t             pair;
    pix_t             lb_rd;
    pix_t             window_max;

    // Result is always one of the two operands, so no width growth.
    function automatic pix_t pick_max(input pix_t a, input pix_t b);
        logic a_ge;
        if (SIGNED != 0) begin
            a_ge = ($signed(a) >= $signed(b));
        end else begin
            a_ge = (a >= b);
        end
        return a_ge ? a : b;
    endfunction

    always_comb begin
        in_ready   = !out_valid_q || bus.OUT_READY;
        in_beat    = bus.IN_VALID && in_ready;
        out_beat   = out_valid_q && bus.OUT_READY;
        col_last   = (col_q == COL_W'(IMG_W - 1));
        row_last   = (row_q == ROW_W'(IMG_H - 1));
        lb_idx     = LB_AW'(col_q >> 1);
        pair       = pick_max(hold_q, bus.IN_DATA);
        lb_rd      = lb_q[lb_idx];
        window_max = pick_max(lb_rd, pair);
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = out_beat && out_last_q;
        lb_we        = 1'b0;

        if (out_beat) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // A load in the same cycle as an output beat overrides the clear above.
        if (in_beat) begin
            col_d = col_last ? '0 : col_q + COL_W'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end

            if (!col_q[0]) begin
                hold_d = bus.IN_DATA;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_data_d  = window_max;
                out_valid_d = 1'b1;
                out_last_d  = row_last && col_last;
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer is not reset: every entry is rewritten on an even row before its odd-row read.
    always_ff @(posedge CLK) begin
        if (lb_we) begin
            lb_q[lb_idx] <= pair;
        end
    end

    assign bus.IN_READY   = in_ready;
    assign bus.OUT_DATA   = out_data_q;
    assign bus.OUT_VALID  = out_valid_q;
    assign bus.FRAME_DONE = frame_done_q;
endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: an 8x8 unsigned instance checked every cycle against a window-max
// model, plus small 4x2 unsigned and 2x2 signed instances pinned with hand-computed results.
module tb_maxpool_stream;
    logic CLK;
    logic rst;

    int checks;
    int failures;

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- DUT instances ----------------
    logic [15:0] m_in_data;
    logic        m_in_valid;
    logic        m_out_ready;
    logic [15:0] s_in_data;
    logic        s_in_valid;
    logic [15:0] g_in_data;
    logic        g_in_valid;

    maxpool_stream_if #(.DATAWIDTH(16)) m_if ();
    maxpool_stream_if #(.DATAWIDTH(16)) s_if ();
    maxpool_stream_if #(.DATAWIDTH(16)) g_if ();

    assign m_if.IN_DATA   = m_in_data;
    assign m_if.IN_VALID  = m_in_valid;
    assign m_if.OUT_READY = m_out_ready;
    assign s_if.IN_DATA   = s_in_data;
    assign s_if.IN_VALID  = s_in_valid;
    assign s_if.OUT_READY = 1'b1;
    assign g_if.IN_DATA   = g_in_data;
    assign g_if.IN_VALID  = g_in_valid;
    assign g_if.OUT_READY = 1'b1;

    maxpool_stream #(.DATAWIDTH(16), .IMG_W(8), .IMG_H(8), .SIGNED(0)) u_main (
        .CLK (CLK),
        .rst (rst),
        .bus (m_if.slave)
    );

    maxpool_stream #(.DATAWIDTH(16), .IMG_W(4), .IMG_H(2), .SIGNED(0)) u_small (
        .CLK (CLK),
        .rst (rst),
        .bus (s_if.slave)
    );

    maxpool_stream #(.DATAWIDTH(16), .IMG_W(2), .IMG_H(2), .SIGNED(1)) u_sgn (
        .CLK (CLK),
        .rst (rst),
        .bus (g_if.slave)
    );

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / model for u_main ----------------
    logic [15:0] exp_q[$];
    logic        exp_last_q[$];
    logic [15:0] mframe [8][8];
    int          mon_beats;
    logic        fd_exp;
    int          out_total;
    int          fd_seen;
    int          out_since_rst;
    logic [15:0] first_after_rst;

    function automatic logic [15:0] max4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        logic [15:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    always @(negedge CLK) begin
        int r;
        int c;
        logic [15:0] e;
        logic        l;
        if (rst) begin
            exp_q.delete();
            exp_last_q.delete();
            mon_beats     = 0;
            fd_exp        = 1'b0;
            out_since_rst = 0;
        end else begin
            chk("frame_done", 32'(m_if.FRAME_DONE), 32'(fd_exp));
            chk("in_ready_rule", 32'(m_if.IN_READY), 32'(!m_if.OUT_VALID || m_if.OUT_READY));
            fd_exp = 1'b0;
            if (m_if.OUT_VALID && m_if.OUT_READY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(m_if.OUT_DATA), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    chk("out_data", 32'(m_if.OUT_DATA), 32'(e));
                    if (l) begin
                        fd_exp = 1'b1;
                        fd_seen++;
                    end
                    out_total++;
                    if (out_since_rst == 0) first_after_rst = m_if.OUT_DATA;
                    out_since_rst++;
                end
            end
            if (m_if.IN_VALID && m_if.IN_READY) begin
                r = mon_beats / 8;
                c = mon_beats % 8;
                mframe[r][c] = m_if.IN_DATA;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_q.push_back(max4(mframe[r-1][c-1], mframe[r-1][c],
                                         mframe[r][c-1], mframe[r][c]));
                    exp_last_q.push_back((r == 7) && (c == 7));
                end
                mon_beats = (mon_beats + 1) % 64;
            end
        end
    end

    // ---------------- collectors for the small instances ----------------
    logic [15:0] s_got[$];
    logic [15:0] g_got[$];
    int          s_fd_cnt;
    int          s_fd_at;

    always @(negedge CLK) begin
        if (!rst) begin
            if (s_if.OUT_VALID && s_if.OUT_READY) s_got.push_back(s_if.OUT_DATA);
            if (s_if.FRAME_DONE) begin
                s_fd_cnt++;
                s_fd_at = s_got.size();
            end
            if (g_if.OUT_VALID && g_if.OUT_READY) g_got.push_back(g_if.OUT_DATA);
        end
    end

    // ---------------- OUT_READY driver for u_main ----------------
    int rdy_mode; // 0 always ready, 1 random, 2 stalled

    initial begin
        m_out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       m_out_ready = 1'b1;
                1:       m_out_ready = ($urandom_range(0, 3) != 0);
                default: m_out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_main(input logic [15:0] d, input bit bubbles);
        bit rdy;
        if (bubbles && ($urandom_range(0, 3) == 0)) begin
            m_in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) begin
                m_in_data = 16'($urandom);
                @(posedge CLK);
                #1;
            end
        end
        m_in_valid = 1'b1;
        m_in_data  = d;
        for (int n = 0; n < 2000; n++) begin
            @(negedge CLK);
            rdy = m_if.IN_READY;
            @(posedge CLK);
            #1;
            if (rdy) begin
                m_in_valid = 1'b0;
                return;
            end
        end
        m_in_valid = 1'b0;
        chk("main_in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_aux(input int which, input logic [15:0] d);
        bit rdy;
        if (which == 0) begin
            s_in_valid = 1'b1;
            s_in_data  = d;
        end else begin
            g_in_valid = 1'b1;
            g_in_data  = d;
        end
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            rdy = (which == 0) ? s_if.IN_READY : g_if.IN_READY;
            @(posedge CLK);
            #1;
            if (rdy) begin
                s_in_valid = 1'b0;
                g_in_valid = 1'b0;
                return;
            end
        end
        s_in_valid = 1'b0;
        g_in_valid = 1'b0;
        chk("aux_in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !m_if.OUT_VALID) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] small_px [8];
        logic [15:0] uns_px [8];
        int          base_total;
        int          base_fd;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        rdy_mode   = 0;
        m_in_valid = 1'b0;
        m_in_data  = '0;
        s_in_valid = 1'b0;
        s_in_data  = '0;
        g_in_valid = 1'b0;
        g_in_data  = '0;
        s_fd_cnt   = 0;
        s_fd_at    = 0;
        out_total  = 0;
        fd_seen    = 0;
        first_after_rst = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_out_valid", 32'(m_if.OUT_VALID), 32'd0);
        chk("reset_out_data", 32'(m_if.OUT_DATA), 32'd0);
        chk("reset_frame_done", 32'(m_if.FRAME_DONE), 32'd0);
        chk("reset_in_ready", 32'(m_if.IN_READY), 32'd1);
        chk("reset_small_out_valid", 32'(s_if.OUT_VALID), 32'd0);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // 4x2 unsigned frame: windows {1,5,4,0} and {2,3,9,7}
        small_px = '{16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd0, 16'd9, 16'd7};
        for (int i = 0; i < 8; i++) send_aux(0, small_px[i]);
        repeat (5) @(posedge CLK);
        #1;
        chk("small_out_count", 32'(s_got.size()), 32'd2);
        chk("small_out0", (s_got.size() > 0) ? 32'(s_got[0]) : 32'hDEAD_BEEF, 32'd5);
        chk("small_out1", (s_got.size() > 1) ? 32'(s_got[1]) : 32'hDEAD_BEEF, 32'd9);
        chk("small_fd_count", 32'(s_fd_cnt), 32'd1);
        chk("small_fd_after_out", 32'(s_fd_at), 32'd2);

        // Same bit patterns compared unsigned: 0xFFFF wins
        uns_px = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h8000, 16'h0001, 16'h0000, 16'h0000};
        for (int i = 0; i < 8; i++) send_aux(0, uns_px[i]);
        repeat (5) @(posedge CLK);
        #1;
        chk("unsigned_win", (s_got.size() > 2) ? 32'(s_got[2]) : 32'hDEAD_BEEF, 32'hFFFF);
        chk("unsigned_win_zero", (s_got.size() > 3) ? 32'(s_got[3]) : 32'hDEAD_BEEF, 32'h0000);
        chk("small_fd_count2", 32'(s_fd_cnt), 32'd2);

        // Signed 2x2 windows
        send_aux(1, 16'hFFFF);
        send_aux(1, 16'h0002);
        send_aux(1, 16'h8000);
        send_aux(1, 16'h0001);
        send_aux(1, 16'h8000);
        send_aux(1, 16'h8001);
        send_aux(1, 16'hFFFE);
        send_aux(1, 16'h8000);
        repeat (4) @(posedge CLK);
        #1;
        chk("signed_count", 32'(g_got.size()), 32'd2);
        chk("signed_win0", (g_got.size() > 0) ? 32'(g_got[0]) : 32'hDEAD_BEEF, 32'h0002);
        chk("signed_win1", (g_got.size() > 1) ? 32'(g_got[1]) : 32'hDEAD_BEEF, 32'hFFFE);

        // Backpressure on u_main: pixel i = 3*i, first window max = pixel(1,1) = 27
        rdy_mode = 2;
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 10; i++) send_main(16'(3 * i), 1'b0);
        m_in_valid = 1'b1;
        m_in_data  = 16'd30;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("stall_out_valid", 32'(m_if.OUT_VALID), 32'd1);
            chk("stall_out_data", 32'(m_if.OUT_DATA), 32'd27);
            chk("stall_in_ready", 32'(m_if.IN_READY), 32'd0);
            chk("stall_no_consume", 32'(mon_beats), 32'd10);
        end
        chk("model_pin_27", (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hDEAD_BEEF, 32'd27);
        @(posedge CLK);
        #1;
        rdy_mode = 0;
        for (int i = 10; i < 64; i++) send_main(16'(3 * i), 1'b0);
        wait_drain("drain_backpressure");
        chk("bp_out_total", 32'(out_total), 32'd16);
        chk("bp_fd_seen", 32'(fd_seen), 32'd1);

        // Three back-to-back random frames with input bubbles and random OUT_READY
        base_total = out_total;
        base_fd    = fd_seen;
        rdy_mode   = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) send_main(16'($urandom), 1'b1);
        end
        wait_drain("drain_random");
        rdy_mode = 0;
        chk("random_out_total", 32'(out_total - base_total), 32'd48);
        chk("random_fd_seen", 32'(fd_seen - base_fd), 32'd3);

        // Asynchronous reset after 11 beats: pixel i = 100+i, window 0 max = 109
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 11; i++) send_main(16'(100 + i), 1'b0);
        @(negedge CLK);
        chk("pre_reset_out_data", 32'(m_if.OUT_DATA), 32'd109);
        @(posedge CLK);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(m_if.OUT_VALID), 32'd0);
        chk("async_rst_out_data", 32'(m_if.OUT_DATA), 32'd0);
        chk("async_rst_frame_done", 32'(m_if.FRAME_DONE), 32'd0);
        chk("async_rst_in_ready", 32'(m_if.IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        base_fd = fd_seen;
        for (int i = 0; i < 64; i++) send_main((i == 9) ? 16'h00F0 : 16'h0010, 1'b0);
        wait_drain("drain_after_reset");
        chk("first_after_reset", 32'(first_after_rst), 32'h00F0);
        chk("outputs_after_reset", 32'(out_since_rst), 32'd16);
        chk("fd_after_reset", 32'(fd_seen - base_fd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 Parameter DATAWIDTH, default 16: bits per pixel.
REQ-002 Parameter IMG_W, default 8: input frame width in pixels; even, >= 2.
REQ-003 Parameter IMG_H, default 8: input frame height in rows; even, >= 2.
REQ-004 Parameter SIGNED, default 0: 0 = unsigned compare; 1 = two's-complement compare.
REQ-005 Port CLK, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port IN_DATA, input, DATAWIDTH: input pixel; frame is streamed row-major, one pixel per beat.
REQ-008 Port IN_VALID, input, 1: IN_DATA valid.
REQ-009 Port IN_READY, output, 1: block accepts a pixel this cycle.
REQ-010 Port OUT_DATA, output, DATAWIDTH: pooled pixel.
REQ-011 Port OUT_VALID, output, 1: OUT_DATA valid.
REQ-012 Port OUT_READY, input, 1: downstream accepts OUT_DATA.
REQ-013 Port FRAME_DONE, output, 1: one-cycle pulse when the last pooled pixel of a frame is accepted downstream.

Function
REQ-014 Input beat = IN_VALID & IN_READY; output beat = OUT_VALID & OUT_READY; no other event advances state.
REQ-015 IN_READY = !OUT_VALID | OUT_READY (combinational); IN_DATA is not required to be held stable when IN_VALID=0.
REQ-016 Column counter col (0..IMG_W-1) increments per input beat, wraps to 0 after IMG_W-1; on wrap, row counter row (0..IMG_H-1) increments and wraps to 0 after IMG_H-1.
REQ-017 Even col: pixel stored in register hold.
REQ-018 Odd col: pair = max(hold, IN_DATA); even row -> line buffer entry lb[col>>1] <= pair; odd row -> OUT_DATA <= max(lb[col>>1], pair), OUT_VALID <= 1.
REQ-019 Line buffer: IMG_W/2 entries of DATAWIDTH bits; entries written only on even rows and read only on odd rows.
REQ-020 Comparison is signed when SIGNED=1, unsigned otherwise; result is always one of the inputs, with no width growth.
REQ-021 Latency: OUT_VALID rises on the clock edge that accepts the pixel at (odd row, odd col); there is one output per 2x2 window, (IMG_W/2)*(IMG_H/2) outputs per frame, in row-major window order.
REQ-022 OUT_VALID clears on an output beat unless a new result is loaded in the same cycle (simultaneous output beat and loading input beat -> OUT_VALID stays 1 with new data).
REQ-023 OUT_DATA and OUT_VALID hold while OUT_VALID=1 and OUT_READY=0; IN_READY=0 in that case, so no input is lost.
REQ-024 FRAME_DONE = 1 for one cycle after the output beat of window (IMG_H/2-1, IMG_W/2-1); frames are back-to-back with no gap required.
REQ-025 Input bubbles (IN_VALID=0) at any position do not alter results.

Reset
REQ-026 On rst=1, regardless of CLK: col=0, row=0, hold=0, OUT_DATA=0, OUT_VALID=0, FRAME_DONE=0; IN_READY=1 follows.
REQ-027 Line buffer contents need not be reset, but are never read before being written in the current frame.
REQ-028 Reset mid-frame discards the partial frame; the first input beat after release is treated as pixel (0,0).

Verification
REQ-029 IMG_W=4, IMG_H=2, unsigned, OUT_READY=1, row0 = 1,5,2,3 and row1 = 4,0,9,7 -> outputs 5 then 9; FRAME_DONE pulses once, after the output 9.
REQ-030 SIGNED=1, DATAWIDTH=16, window 0xFFFF,0x0002,0x8000,0x0001 -> output 0x0002; with SIGNED=0 the same window -> 0xFFFF.
REQ-031 Backpressure: OUT_READY=0 for 5 cycles with OUT_VALID=1 -> OUT_DATA stable, IN_READY=0, no input consumed; release -> stream continues with no loss or duplication.
REQ-032 Random IN_VALID/OUT_READY toggling over 3 back-to-back 8x8 frames -> output sequence matches a reference 2x2 max model; 16 outputs and 1 FRAME_DONE per frame.
REQ-033 Assert rst asynchronously after 11 input beats -> all outputs 0 within the same cycle; next frame (all pixels = 0x0010 except pixel (1,1) = 0x00F0) -> first output 0x00F0.
